button_event_ctrl: RTL and testbench

- Event controller behind the per-button debouncers. Takes N debounced button levels and generates PRESS, RELEASE, LONG and REPEAT events for each button.
- Queues at most one pending event of each type per button.
- Shares a single event output port between all buttons using round-robin arbitration and a valid/ready handshake. Downstream logic (menu/CPU/display FSM) consumes one event at a time.

---
 rtl/button_pkg.sv | 22 ++
 rtl/button_tracker.sv | 86 ++++++++
 rtl/button_event_ctrl.sv | 120 ++++++++++++
 tb/tb_button_event_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing for the button event controller.
package button_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } trk_state_e;

  localparam int unsigned DEF_N_BTN         = 4;
  localparam int unsigned DEF_LONG_CYCLES   = 50000000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10000000;
  localparam int unsigned DEF_CNT_W         = 26;

endpackage

// File: rtl/button_tracker.sv
// Per-button hold tracker: press/long/repeat/release detection plus one pending bit per event type.
module button_tracker
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rise,
  input  logic       fall,
  input  logic       repeat_en,
  input  evt_type_e  grant_type,
  input  logic       grant_valid,
  output logic [3:0] pending,
  output logic       overrun_pulse
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

  trk_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       raise;
  logic [3:0]       granted;

  // Event raise decode; a fall always wins over a terminal count.
  always_comb begin
    raise = '0;
    unique case (state)
      IDLE:    raise[EVT_PRESS] = rise;
      HELD: begin
        if (fall)                raise[EVT_RELEASE] = 1'b1;
        else if (cnt == LONG_TC) raise[EVT_LONG]    = 1'b1;
      end
      REPEAT: begin
        if (fall)                            raise[EVT_RELEASE] = 1'b1;
        else if (repeat_en && cnt == REP_TC) raise[EVT_REPEAT]  = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter only ever reaches the terminal value before returning to 0, so it cannot wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= HELD;
            cnt   <= '0;
          end
        end
        HELD: begin
          if (fall) begin
            state <= IDLE;
          end else if (cnt == LONG_TC) begin
            state <= REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (fall)                           state <= IDLE;
          else if (!repeat_en || cnt == REP_TC) cnt <= '0;
          else                                cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign granted       = grant_valid ? (4'(1) << grant_type) : 4'b0000;
  assign overrun_pulse = |(raise & pending & ~granted);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= (pending & ~granted) | raise;
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: edge detect, per-button trackers, round-robin arbiter and shared event port.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int unsigned N_BTN         = DEF_N_BTN,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_BTN-1:0]         btn_in,
  input  logic                     repeat_en,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic [1:0]               evt_type,
  output logic [N_BTN-1:0]         overrun,
  input  logic                     overrun_clr,
  output logic [N_BTN-1:0]         btn_state
);

  localparam int unsigned      IDX_W    = $clog2(N_BTN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BTN - 1);

  if ((64'(LONG_CYCLES) > (64'(1) << CNT_W)) || (64'(REPEAT_CYCLES) > (64'(1) << CNT_W)))
  begin : g_cnt_w_check
    $error("button_event_ctrl: LONG_CYCLES/REPEAT_CYCLES exceed 2**CNT_W");
  end

  logic [N_BTN-1:0]      rise;
  logic [N_BTN-1:0]      fall;
  logic [N_BTN-1:0][3:0] pending;
  logic [N_BTN-1:0]      eligible;
  logic [N_BTN-1:0]      grant_vec;
  logic [N_BTN-1:0]      ovr_pulse;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;
  evt_type_e             gnt_type;
  logic [3:0]            pend_sel;
  logic                  load;
  logic                  fire;

  assign rise = btn_in & ~btn_state;
  assign fall = ~btn_in & btn_state;

  for (genvar i = 0; i < N_BTN; i++) begin : g_trk
    button_tracker #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_trk (
      .clk          (clk),
      .reset_n      (reset_n),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .repeat_en    (repeat_en),
      .grant_type   (gnt_type),
      .grant_valid  (grant_vec[i]),
      .pending      (pending[i]),
      .overrun_pulse(ovr_pulse[i])
    );
    assign eligible[i]  = |pending[i];
    assign grant_vec[i] = fire && (gnt_idx == IDX_W'(i));
  end

  // Round-robin search starting at the pointer.
  always_comb begin
    int unsigned      j;
    logic [IDX_W-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    cand    = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      j = 32'(ptr) + k;
      if (j >= N_BTN) j = j - N_BTN;
      cand = IDX_W'(j);
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // PRESS before LONG/REPEAT before RELEASE keeps the press/release order intact.
  always_comb begin
    pend_sel = pending[gnt_idx];
    if (pend_sel[EVT_PRESS])       gnt_type = EVT_PRESS;
    else if (pend_sel[EVT_LONG])   gnt_type = EVT_LONG;
    else if (pend_sel[EVT_REPEAT]) gnt_type = EVT_REPEAT;
    else                           gnt_type = EVT_RELEASE;
  end

  assign load = !evt_valid || evt_ready;
  assign fire = load && gnt_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_state <= '0;
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_type  <= 2'd0;
      ptr       <= '0;
      overrun   <= '0;
    end else begin
      btn_state <= btn_in;
      if (load) evt_valid <= gnt_any;
      if (fire) begin
        evt_btn  <= gnt_idx;
        evt_type <= gnt_type;
        ptr      <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
      end
      if (overrun_clr) overrun <= '0;
      else             overrun <= overrun | ovr_pulse;
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: expected events queued at stimulus time, checked on each handshake.
module tb_button_event_ctrl;

  localparam int T_PRESS   = 0;
  localparam int T_RELEASE = 1;
  localparam int T_LONG    = 2;
  localparam int T_REPEAT  = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn_in;
  logic       repeat_en;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_btn;
  logic [1:0] evt_type;
  logic [3:0] overrun;
  logic       overrun_clr;
  logic [3:0] btn_state;

  typedef struct {
    int btn;
    int typ;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   c;

  button_event_ctrl #(
    .N_BTN        (4),
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_in     (btn_in),
    .repeat_en  (repeat_en),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_btn    (evt_btn),
    .evt_type   (evt_type),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .btn_state  (btn_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int b, input int t, input int cy);
    exp_t e;
    e.btn = b;
    e.typ = t;
    e.cyc = cy;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every accepted event must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset_n && evt_valid && evt_ready) begin
      total++;
      assert (q.size() !== 0) else begin
        bad++;
        $error("FAIL unexpected_event observed=btn%0d/type%0d expected=none", evt_btn, evt_type);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("evt_btn", 32'(evt_btn), 32'(e.btn));
        chk("evt_type", 32'(evt_type), 32'(e.typ));
        if (e.cyc >= 0) chk("evt_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    btn_in      = 4'b0000;
    repeat_en   = 1'b0;
    evt_ready   = 1'b1;
    overrun_clr = 1'b0;
    tick(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_btn", 32'(evt_btn), 32'd0);
    chk("rst_type", 32'(evt_type), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_btn_state", 32'(btn_state), 32'd0);
    reset_n = 1'b1;
    tick(5);

    // Short press/release on button 2
    c = cyc;
    btn_in[2] = 1'b1;
    push(2, T_PRESS, c + 2);
    tick(3);
    btn_in[2] = 1'b0;
    push(2, T_RELEASE, c + 5);
    tick(8);

    // Long hold with repeat; the final repeat count coincides with the fall
    repeat_en = 1'b1;
    c = cyc;
    btn_in[0] = 1'b1;
    push(0, T_PRESS, c + 2);
    push(0, T_LONG, c + 10);
    push(0, T_REPEAT, c + 14);
    push(0, T_REPEAT, c + 18);
    tick(5);
    chk("btn_state_held", 32'(btn_state), 32'd1);
    tick(15);
    btn_in[0] = 1'b0;
    push(0, T_RELEASE, c + 22);
    tick(8);

    // Long hold without repeat
    repeat_en = 1'b0;
    c = cyc;
    btn_in[0] = 1'b1;
    push(0, T_PRESS, c + 2);
    push(0, T_LONG, c + 10);
    tick(20);
    btn_in[0] = 1'b0;
    push(0, T_RELEASE, c + 22);
    tick(8);

    // Round robin from a freshly reset pointer
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    c = cyc;
    btn_in = 4'b1111;
    for (int i = 0; i < 4; i++) push(i, T_PRESS, c + 2 + i);
    tick(6);
    btn_in = 4'b0000;
    for (int i = 0; i < 4; i++) push(i, T_RELEASE, c + 8 + i);
    tick(10);

    // Move the pointer to 2, then burst again
    c = cyc;
    btn_in[1] = 1'b1;
    push(1, T_PRESS, c + 2);
    tick(3);
    btn_in[1] = 1'b0;
    push(1, T_RELEASE, c + 5);
    tick(6);
    c = cyc;
    btn_in = 4'b1111;
    for (int i = 0; i < 4; i++) push((i + 2) % 4, T_PRESS, c + 2 + i);
    tick(6);
    btn_in = 4'b0000;
    for (int i = 0; i < 4; i++) push((i + 2) % 4, T_RELEASE, c + 8 + i);
    tick(10);

    // Backpressure: second release on button 1 finds its bit still pending
    evt_ready = 1'b0;
    btn_in[1] = 1'b1;
    tick(2);
    btn_in[1] = 1'b0;
    tick(2);
    btn_in[1] = 1'b1;
    tick(2);
    btn_in[1] = 1'b0;
    tick(10);
    chk("bp_valid_a", 32'(evt_valid), 32'd1);
    chk("bp_btn_a", 32'(evt_btn), 32'd1);
    chk("bp_type_a", 32'(evt_type), 32'(T_PRESS));
    tick(10);
    chk("bp_valid_b", 32'(evt_valid), 32'd1);
    chk("bp_btn_b", 32'(evt_btn), 32'd1);
    chk("bp_type_b", 32'(evt_type), 32'(T_PRESS));
    chk("bp_overrun", 32'(overrun), 32'b0010);
    tick(4);
    c = cyc;
    push(1, T_PRESS, c);
    push(1, T_PRESS, c + 1);
    push(1, T_RELEASE, c + 2);
    evt_ready = 1'b1;
    tick(6);
    chk("overrun_sticky", 32'(overrun), 32'b0010);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    chk("overrun_cleared", 32'(overrun), 32'd0);
    tick(4);

    // Reset while button 0 is repeating with events stuck behind backpressure
    repeat_en = 1'b1;
    evt_ready = 1'b0;
    c = cyc;
    btn_in[0] = 1'b1;
    tick(14);
    chk("pre_rst_valid", 32'(evt_valid), 32'd1);
    chk("pre_rst_btn", 32'(evt_btn), 32'd0);
    chk("pre_rst_type", 32'(evt_type), 32'(T_PRESS));
    tick(1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(evt_valid), 32'd0);
    chk("async_rst_btn_state", 32'(btn_state), 32'd0);
    chk("async_rst_type", 32'(evt_type), 32'd0);
    chk("async_rst_overrun", 32'(overrun), 32'd0);
    tick(1);
    c = cyc;
    reset_n   = 1'b1;
    repeat_en = 1'b0;
    evt_ready = 1'b1;
    push(0, T_PRESS, c + 2);
    push(0, T_LONG, c + 10);
    tick(12);
    btn_in[0] = 1'b0;
    push(0, T_RELEASE, c + 14);
    tick(8);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
